// File: rtl/airi5c_rshift_sched.sv
// Iterative sign-fill right-shift scheduler: two round-robin requesters share one
// bounded per-cycle shifter; the sticky bit accumulates across steps.
module airi5c_rshift_sched #(
    parameter int unsigned n = 32,
    parameter int unsigned s = 8,
    parameter int unsigned k = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_data,
    input  logic [s-1:0] req0_amt,
    input  logic         req0_sgn,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_data,
    input  logic [s-1:0] req1_amt,
    input  logic         req1_sgn,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_data,
    output logic         rsp_sticky,
    output logic         rsp_id,
    output logic         busy
);
    localparam int unsigned M  = (1 << k) - 1;
    localparam int unsigned RW = $clog2(n + 1);
    localparam int unsigned AW = (s > RW) ? s : RW;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_pri;
    logic           r_sgn;
    logic           r_sticky;
    logic           r_id;
    logic [n-1:0]   r_data;
    logic [RW-1:0]  r_rem;

    logic           w_idle;
    logic           w_accept;
    logic           w_sel;
    logic [n-1:0]   w_in_data;
    logic [AW-1:0]  w_in_amt;
    logic           w_in_sgn;
    logic [RW-1:0]  w_in_r;
    logic [k-1:0]   w_step;
    logic [RW-1:0]  w_rem_nxt;
    logic [n-1:0]   w_shifted;
    logic [n-1:0]   w_mask;
    logic           w_out_bits;

    // Grants are suppressed while reset is asserted so every output reads 0.
    assign w_idle     = (r_state == S_IDLE) & ~reset;
    assign req0_ready = w_idle & req0_valid & (~r_pri | ~req1_valid);
    assign req1_ready = w_idle & req1_valid & (r_pri | ~req0_valid);
    assign w_accept   = req0_ready | req1_ready;
    assign w_sel      = req1_ready;

    assign w_in_data = w_sel ? req1_data : req0_data;
    assign w_in_amt  = w_sel ? AW'(req1_amt) : AW'(req0_amt);
    assign w_in_sgn  = w_sel ? req1_sgn : req0_sgn;
    assign w_in_r    = (w_in_amt >= AW'(n)) ? RW'(n) : RW'(w_in_amt);

    // One bounded step: t = min(rem, M); shifted-out bits feed the sticky.
    assign w_step     = (r_rem > RW'(M)) ? k'(M) : k'(r_rem);
    assign w_rem_nxt  = r_rem - RW'(w_step);
    assign w_mask     = ~({n{1'b1}} << w_step);
    assign w_shifted  = (r_data >> w_step) | (r_sgn ? ~({n{1'b1}} >> w_step) : '0);
    assign w_out_bits = |(r_data & w_mask);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (w_in_r == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (w_rem_nxt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pri    <= 1'b0;
            r_sgn    <= 1'b0;
            r_sticky <= 1'b0;
            r_id     <= 1'b0;
            r_data   <= '0;
            r_rem    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_data   <= w_in_data;
                r_sgn    <= w_in_sgn;
                r_rem    <= w_in_r;
                r_sticky <= 1'b0;
                r_id     <= w_sel;
                r_pri    <= ~w_sel;
            end
        end else if (r_state == S_SHIFT) begin
            r_data   <= w_shifted;
            r_sticky <= r_sticky | w_out_bits;
            r_rem    <= w_rem_nxt;
        end
    end

    assign rsp_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign rsp_data   = r_data;
    assign rsp_sticky = r_sticky;
    assign rsp_id     = r_id;
endmodule

// File: tb/tb_airi5c_rshift_sched.sv
// Bench for airi5c_rshift_sched: directed boundary cases, randomized transactions,
// round-robin fairness, response stall and mid-shift reset against a reference model.
module tb_airi5c_rshift_sched;
    localparam int unsigned N = 32;
    localparam int unsigned S = 8;
    localparam int unsigned K = 3;
    localparam int unsigned M = (1 << K) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req0_sgn;
    logic         req1_valid, req1_ready, req1_sgn;
    logic [N-1:0] req0_data, req1_data;
    logic [S-1:0] req0_amt, req1_amt;
    logic         rsp_valid, rsp_ready, rsp_sticky, rsp_id, busy;
    logic [N-1:0] rsp_data;

    int n_vec = 0;
    int n_err = 0;

    airi5c_rshift_sched #(.n(N), .s(S), .k(K)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_sgn(req0_sgn),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_sgn(req1_sgn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_sticky(rsp_sticky), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: arithmetic on the clamped amount.
    function automatic int unsigned clamp(input int unsigned amt);
        return (amt > N) ? N : amt;
    endfunction

    function automatic logic [N-1:0] ref_data(input logic [N-1:0] d, input int unsigned amt,
                                              input logic g);
        int unsigned r = clamp(amt);
        logic [N-1:0] ones = '1;
        return (d >> r) | (g ? ~(ones >> r) : '0);
    endfunction

    function automatic logic ref_sticky(input logic [N-1:0] d, input int unsigned amt);
        int unsigned r = clamp(amt);
        logic [63:0] mask;
        if (r == 0) return 1'b0;
        mask = (64'd1 << r) - 64'd1;
        return |({32'd0, d} & mask);
    endfunction

    function automatic int ref_lat(input int unsigned amt);
        int unsigned r = clamp(amt);
        return (r == 0) ? 1 : int'((r + M - 1) / M) + 1;
    endfunction

    task automatic drive(input int p, input logic v, input logic [N-1:0] d,
                         input logic [S-1:0] a, input logic g);
        if (p == 0) begin
            req0_valid = v; req0_data = d; req0_amt = a; req0_sgn = g;
        end else begin
            req1_valid = v; req1_data = d; req1_amt = a; req1_sgn = g;
        end
    endtask

    task automatic set_valid(input int p, input logic v);
        if (p == 0) req0_valid = v;
        else        req1_valid = v;
    endtask

    // One full transaction; entered and left at posedge+1 with the DUT idle.
    task automatic run_one(input int p, input logic [N-1:0] d, input int unsigned amt,
                           input logic g, input int stall);
        logic [N-1:0] ed = ref_data(d, amt, g);
        logic         es = ref_sticky(d, amt);
        int lat;
        drive(p, 1'b1, d, S'(amt), g);
        #1;
        chk("req_ready", (p == 0) ? req0_ready : req1_ready, 1);
        @(posedge clk); #1;
        set_valid(p, 1'b0);
        chk("busy_rise", busy, 1);
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(ref_lat(amt)));
        chk("rsp_data", rsp_data, ed);
        chk("rsp_sticky", rsp_sticky, es);
        chk("rsp_id", rsp_id, 64'(p));
        if (stall > 0) set_valid(1 - p, 1'b1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, ed);
            chk("stall_sticky", rsp_sticky, es);
            chk("stall_id", rsp_id, 64'(p));
            chk("stall_no_rdy", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("busy_fall", busy, 0);
        set_valid(1 - p, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int q[$];
        int exp_next, grants, p, sel, amt, bound;
        logic [N-1:0] d;

        reset = 1'b1; rsp_ready = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        #2;
        chk("rst_outputs", {rsp_valid, rsp_sticky, rsp_id, busy, req0_ready, req1_ready}, 0);
        chk("rst_data", rsp_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases, including M / M+1 and n / 2n boundaries.
        run_one(0, 32'h800000F0, 4, 1'b0, 0);
        run_one(0, 32'h800000F0, 5, 1'b0, 0);
        run_one(1, 32'hFFFFFFFF, 20, 1'b0, 0);
        run_one(0, 32'h00000001, 200, 1'b1, 0);
        run_one(0, 32'h12345678, 0, 1'b0, 0);
        run_one(1, 32'hDEADBEEF, M, 1'b1, 0);
        run_one(0, 32'hDEADBEEF, M + 1, 1'b1, 0);
        run_one(1, 32'hA5A5A5A5, N, 1'b0, 0);
        run_one(0, 32'hA5A5A5A5, 2 * N, 1'b0, 0);
        run_one(1, 32'h0F00F00F, 9, 1'b1, 3);

        for (int it = 0; it < 150; it++) begin
            p   = int'($urandom_range(0, 1));
            d   = $urandom;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       amt = int'($urandom_range(0, 8));
                1:       amt = int'($urandom_range(0, 255));
                2:       amt = int'($urandom_range(28, 40));
                default: amt = int'($urandom_range(0, 31));
            endcase
            run_one(p, d, amt, 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Both requesters continuously valid from reset: strict alternation.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b1, 32'h0000F00F, 8'd3, 1'b0);
        drive(1, 1'b1, 32'h80001234, 8'd10, 1'b1);
        rsp_ready = 1'b1;
        exp_next = 0; grants = 0;
        #1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            chk("one_ready", req0_ready & req1_ready, 0);
            chk("ready_only_idle", (req0_ready | req1_ready) & busy, 0);
            if (req0_ready || req1_ready) begin
                chk("grant_order", req1_ready, 64'(exp_next));
                q.push_back(exp_next);
                exp_next = 1 - exp_next;
                grants++;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_without_grant", 1, 0);
                end else begin
                    p = q.pop_front();
                    chk("rr_id", rsp_id, 64'(p));
                    chk("rr_data", rsp_data, (p == 0) ? ref_data(32'h0000F00F, 3, 1'b0)
                                                      : ref_data(32'h80001234, 10, 1'b1));
                end
            end
            @(posedge clk); #1;
        end
        chk("rr_grants", 64'(grants >= 8), 1);
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        bound = 0;
        while (busy && bound < 40) begin
            @(posedge clk); #1;
            bound++;
        end
        chk("drain_idle", busy, 0);
        rsp_ready = 1'b0;

        // Reset in the middle of a long shift; pri was 1 after the grant to req0.
        drive(0, 1'b1, 32'h00000001, 8'd200, 1'b1);
        #1;
        @(posedge clk); #1;
        set_valid(0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", busy, 1);
        chk("mid_not_done", rsp_valid, 0);
        drive(0, 1'b1, 32'h12345678, 8'd13, 1'b0);
        drive(1, 1'b1, 32'h87654321, 8'd2, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", {rsp_valid, rsp_sticky, rsp_id, busy, req0_ready, req1_ready}, 0);
        chk("rst_mid_data", rsp_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_pri", {req0_ready, req1_ready}, 2'b10);
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        @(posedge clk); #1;
        chk("rst_idle", busy, 0);
        run_one(0, 32'h12345678, 13, 1'b0, 0);
        run_one(1, 32'h87654321, 2, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/airi5c_rshift_sched.md
# airi5c_rshift_sched

Iterative right-shift scheduler for the AIRI5C FPU. It shares one narrow sign-fill barrel right shifter between two requesters, for example the adder alignment path and the float-to-int converter. It sequences any shift amount as a series of bounded per-cycle steps and accumulates the sticky bit across steps. The result is returned over a valid/ready handshake.

## Interface
- `n`, default 32: data width.
- `s`, default 8: shift-amount width.
- `k`, default 3: select width of the embedded per-step shifter; maximum step M = 2^k − 1.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `req0_valid` / `req1_valid` input, 1 bit each: request valid.
- `req0_ready` / `req1_ready` output, 1 bit each: request accepted this cycle.
- `req0_data` / `req1_data` input, n bits each: operand.
- `req0_amt` / `req1_amt` input, s bits each: shift amount, unsigned.
- `req0_sgn` / `req1_sgn` input, 1 bit each: fill bit for vacated MSBs.
- `rsp_valid` output, 1 bit: result valid.
- `rsp_ready` input, 1 bit: consumer accepts result.
- `rsp_data` output, n bits: shifted result.
- `rsp_sticky` output, 1 bit: OR of all bits shifted out.
- `rsp_id` output, 1 bit: index of the requester that is served.
- `busy` output, 1 bit: state ≠ IDLE.

## Operation
- States:
  - IDLE → SHIFT on accept with clamped amount r > 0.
  - IDLE → DONE on accept with r = 0.
  - SHIFT → SHIFT while the remaining amount after the step is > 0.
  - SHIFT → DONE when the remaining amount reaches 0.
  - DONE → IDLE on `rsp_valid & rsp_ready`.
- Accept (IDLE only):
  - Capture data, sgn, and r = min(amt, n) into the working registers.
  - Clear the sticky accumulator.
  - Record `rsp_id`.
- Arbitration: round-robin with a priority pointer `pri`.
  - `req0_ready = IDLE & req0_valid & (pri==0 | !req1_valid)`.
  - `req1_ready` is symmetric.
  - Ready may depend on valid. Valid must not depend on ready.
  - On grant, `pri` moves to the other requester.
  - A lone requester is granted regardless of `pri`.
- Each SHIFT cycle:
  - Step t = min(rem, M).
  - `data <= data >> t`, with the vacated bits filled with sgn.
  - `sticky <= sticky | (OR of data[t−1:0])`.
  - `rem <= rem − t`.
- Result definition:
  - `rsp_data` = `in` shifted right by min(amt, n) with sgn fill.
  - `rsp_sticky` = OR of `in[min(amt,n)−1:0]`, and 0 when amt = 0.
  - Fill bits are never counted into sticky, because of the clamp to n.
- Amount ≥ n:
  - Result is all sgn bits.
  - Sticky = `|in`.
  - Never more than ceil(n/M) steps.
- DONE:
  - `rsp_*` held stable until handshake.
  - Requests are not accepted in the same cycle as the response handshake; the block returns to IDLE first.
- Reset (asynchronous, any state, including mid-SHIFT or DONE):
  - State = IDLE, `pri` = 0.
  - All outputs are 0: `rsp_valid`, `rsp_data`, `rsp_sticky`, `rsp_id`, `busy`, `req*_ready`.
  - Any in-flight transaction is discarded.

## Timing
- Accept happens at clock edge E0.
- `rsp_valid` rises ceil(r/M)+1 cycles after E0; for r = 0 it rises 1 cycle after E0.
- `busy` rises the cycle after E0 and falls the cycle after the response handshake.
- Minimum spacing between accepts: latency + 1 cycle (the return to IDLE).
- Request interface: inputs are sampled only on the accept edge. The requester must hold its inputs while valid and not ready.
- `rsp_data`, `rsp_sticky` and `rsp_id` are registered outputs. `req*_ready` is combinational from state, `pri` and the valids.
- Boundaries:
  - amt = n: same result as amt = 2n.
  - amt = M: exactly 1 SHIFT cycle.
  - amt = M+1: 2 SHIFT cycles (M, then 1).

## Test plan
- req0 data=0x800000F0, amt=4, sgn=0 → `rsp_data`=0x0800000F, sticky=0, id=0, `rsp_valid` 2 cycles after accept. Repeat with amt=5 → 0x04000007, sticky=1.
- req1 data=0xFFFFFFFF, amt=20, sgn=0 → 0x00000FFF, sticky=1, id=1. Exactly 3 SHIFT cycles (7, 7, 6); `rsp_valid` 4 cycles after accept.
- req0 data=0x00000001, amt=200, sgn=1 → 0xFFFFFFFF, sticky=1; 5 SHIFT cycles. Also amt=0, data=0x12345678 → unchanged, sticky=0, 1-cycle latency.
- Both valid from reset, continuously:
  - Grants alternate 0, 1, 0, 1.
  - `rsp_id` follows the grant order.
  - Only one ready is high per cycle, and only in IDLE.
- Hold `rsp_ready` low 3 cycles in DONE → `rsp_data`, `rsp_sticky` and `rsp_id` stay stable and there is no new accept. Assert `reset` mid-SHIFT → all outputs 0 immediately, state IDLE, `pri`=0, and the next request is served correctly.
